// File: rtl/info_marker_gen_if.sv
// Request/instruction handshake bundle for info_marker_gen.
// The slave modport is the generator's view; master is the driver/consumer side.
interface info_marker_gen_if;
  logic        req_valid;
  logic [3:0]  req_code;
  logic        req_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;

  modport master (
    output req_valid, req_code, inst_ready,
    input  req_ready, inst_valid, inst
  );

  modport slave (
    input  req_valid, req_code, inst_ready,
    output req_ready, inst_valid, inst
  );
endinterface

// File: rtl/info_marker_gen.sv
// Phase-event marker generator: queues legal event codes and emits them as slti x0,x0,code words.
// Optional phase-ordering checks are compiled in with INFO_PHASE_CHECK_EN.
module info_marker_gen #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  info_marker_gen_if.slave   bus,
  input  logic               flush,
  output logic [6:0]         open_phases,
  output logic               err_illegal,
  output logic               err_order,
  output logic [15:0]        emit_count
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  function automatic logic [31:0] encode_marker(input logic [3:0] code);
    return {8'h00, code, 20'h02013};
  endfunction

  logic [3:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [6:0]    open_phases_r;
  logic          err_illegal_r;
  logic [15:0]   emit_count_r;

  logic          full_s;
  logic          req_ready_s;
  logic          inst_valid_s;
  logic          accept_s;
  logic          code_illegal_s;
  logic          is_start_s;
  logic [6:0]    phase_mask_s;
  logic [6:0]    phases_next_s;
  logic          order_bad_s;
  logic          push_s;
  logic          pop_s;

  // Handshake qualification, ordering check and phase-vector next value.
  always_comb begin
    full_s         = (count_r == (AW+1)'(FIFO_DEPTH));
    req_ready_s    = !full_s && !flush;
    inst_valid_s   = (count_r != {(AW+1){1'b0}});
    accept_s       = bus.req_valid && req_ready_s;
    code_illegal_s = (bus.req_code[3:1] == 3'b111);
    is_start_s     = ~bus.req_code[0];
    phase_mask_s   = 7'b0000001 << bus.req_code[3:1];
    order_bad_s    = 1'b0;
`ifdef INFO_PHASE_CHECK_EN
    if (code_illegal_s) begin
      order_bad_s = 1'b0;
    end else if (is_start_s) begin
      order_bad_s = |(open_phases_r & phase_mask_s);
    end else begin
      order_bad_s = ~|(open_phases_r & phase_mask_s);
    end
`endif
    push_s = accept_s && !code_illegal_s && !order_bad_s;
    pop_s  = inst_valid_s && bus.inst_ready;
    if (is_start_s) begin
      phases_next_s = open_phases_r | phase_mask_s;
    end else begin
      phases_next_s = open_phases_r & ~phase_mask_s;
    end
  end

  // FIFO storage, pointers, phase state, sticky error and emit counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 4'h0;
      end
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      count_r       <= {(AW+1){1'b0}};
      open_phases_r <= 7'b0000000;
      err_illegal_r <= 1'b0;
      emit_count_r  <= 16'h0000;
    end else begin
      if (pop_s) begin
        emit_count_r <= emit_count_r + 16'h0001;
      end
      if (accept_s && code_illegal_s) begin
        err_illegal_r <= 1'b1;
      end
      if (flush) begin
        wr_ptr_r      <= {AW{1'b0}};
        rd_ptr_r      <= {AW{1'b0}};
        count_r       <= {(AW+1){1'b0}};
        open_phases_r <= 7'b0000000;
      end else begin
        if (push_s) begin
          mem_r[wr_ptr_r] <= bus.req_code;
          wr_ptr_r        <= wr_ptr_r + AW'(1);
          open_phases_r   <= phases_next_s;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + (AW+1)'(1);
          2'b01:   count_r <= count_r - (AW+1)'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

`ifdef INFO_PHASE_CHECK_EN
  logic err_order_r;

  // Sticky record of a dropped out-of-order phase event.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_order_r <= 1'b0;
    end else if (accept_s && order_bad_s) begin
      err_order_r <= 1'b1;
    end
  end

  assign err_order = err_order_r;
`else
  assign err_order = 1'b0;
`endif

  assign bus.req_ready  = req_ready_s;
  assign bus.inst_valid = inst_valid_s;
  assign bus.inst       = inst_valid_s ? encode_marker(mem_r[rd_ptr_r]) : 32'h0000_0000;
  assign open_phases    = open_phases_r;
  assign err_illegal    = err_illegal_r;
  assign emit_count     = emit_count_r;

endmodule

// File: tb/tb_info_marker_gen.sv
// Directed self-checking bench for info_marker_gen (FIFO_DEPTH = 4).
// Expectations follow INFO_PHASE_CHECK_EN where the ordering check changes behaviour.
module tb_info_marker_gen;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic [6:0]  open_phases;
  logic        err_illegal;
  logic        err_order;
  logic [15:0] emit_count;

  int n_checks;
  int n_errors;

  info_marker_gen_if bus ();

  info_marker_gen #(.FIFO_DEPTH(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .flush       (flush),
    .open_phases (open_phases),
    .err_illegal (err_illegal),
    .err_order   (err_order),
    .emit_count  (emit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    #2;
    check_eq("rst_release_ready", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    logic [3:0] codes [4];
    n_checks       = 0;
    n_errors       = 0;
    reset_n        = 1'b0;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_code   = 4'h0;
    bus.inst_ready = 1'b0;
    codes[0] = 4'd0; codes[1] = 4'd2; codes[2] = 4'd4; codes[3] = 4'd6;

    step();
    check_eq("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check_eq("rst_inst", bus.inst, 32'h0000_0000);
    check_eq("rst_open", {25'd0, open_phases}, 32'd0);
    check_eq("rst_err_illegal", {31'd0, err_illegal}, 32'd0);
    check_eq("rst_err_order", {31'd0, err_order}, 32'd0);
    check_eq("rst_emit", {16'd0, emit_count}, 32'd0);
    step();
    reset_n = 1'b1;
    #2;
    check_eq("first_ready", {31'd0, bus.req_ready}, 32'd1);

    // Single marker: code 4 with consumer ready
    bus.inst_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_code   = 4'd4;
    step();
    bus.req_valid = 1'b0;
    check_eq("t1_valid", {31'd0, bus.inst_valid}, 32'd1);
    check_eq("t1_inst", bus.inst, 32'h0040_2013);
    check_eq("t1_open", {25'd0, open_phases}, 32'h04);
    check_eq("t1_emit_pre", {16'd0, emit_count}, 32'd0);
    step();
    check_eq("t1_emit", {16'd0, emit_count}, 32'd1);
    check_eq("t1_drained", {31'd0, bus.inst_valid}, 32'd0);

    // Fill to capacity, then drain one per cycle in order
    do_reset();
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_code  = codes[i];
      step();
    end
    bus.req_valid = 1'b0;
    check_eq("t2_full_ready", {31'd0, bus.req_ready}, 32'd0);
    check_eq("t2_open", {25'd0, open_phases}, 32'h0F);
    step();
    check_eq("t2_hold", bus.inst, 32'h0000_2013);
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_order", bus.inst, {8'h00, codes[i], 20'h02013});
      check_eq("t2_valid", {31'd0, bus.inst_valid}, 32'd1);
      step();
    end
    check_eq("t2_empty", {31'd0, bus.inst_valid}, 32'd0);
    check_eq("t2_emit", {16'd0, emit_count}, 32'd4);

    // Illegal code consumed, not queued, sticky error
    bus.req_valid = 1'b1;
    bus.req_code  = 4'd15;
    step();
    bus.req_valid = 1'b0;
    check_eq("t3_no_inst", {31'd0, bus.inst_valid}, 32'd0);
    check_eq("t3_err", {31'd0, err_illegal}, 32'd1);
    check_eq("t3_open", {25'd0, open_phases}, 32'h0F);
    step();
    step();
    check_eq("t3_sticky", {31'd0, err_illegal}, 32'd1);
    check_eq("t3_emit", {16'd0, emit_count}, 32'd4);

    // Reset while entries are queued
    bus.inst_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_code   = 4'd8;
    step();
    bus.req_code   = 4'd10;
    step();
    bus.req_valid = 1'b0;
    check_eq("t4_queued", {31'd0, bus.inst_valid}, 32'd1);
    do_reset();
    check_eq("t4_err_cleared", {31'd0, err_illegal}, 32'd0);
    check_eq("t4_emit_cleared", {16'd0, emit_count}, 32'd0);

    // End code for a never-opened phase
    bus.inst_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_code   = 4'd7;
    step();
    bus.req_valid = 1'b0;
`ifdef INFO_PHASE_CHECK_EN
    check_eq("t5_dropped", {31'd0, bus.inst_valid}, 32'd0);
    check_eq("t5_err_order", {31'd0, err_order}, 32'd1);
    step();
    check_eq("t5_emit", {16'd0, emit_count}, 32'd0);
`else
    check_eq("t5_valid", {31'd0, bus.inst_valid}, 32'd1);
    check_eq("t5_inst", bus.inst, 32'h0070_2013);
    check_eq("t5_err_order", {31'd0, err_order}, 32'd0);
    step();
    check_eq("t5_emit", {16'd0, emit_count}, 32'd1);
`endif
    check_eq("t5_open", {25'd0, open_phases}, 32'd0);

    // Flush with a competing push
    do_reset();
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1;
      bus.req_code  = codes[i];
      step();
    end
    check_eq("t6_open_pre", {25'd0, open_phases}, 32'h07);
    flush        = 1'b1;
    bus.req_code = 4'd6;
    #1;
    check_eq("t6_flush_ready", {31'd0, bus.req_ready}, 32'd0);
    step();
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    check_eq("t6_valid", {31'd0, bus.inst_valid}, 32'd0);
    check_eq("t6_open", {25'd0, open_phases}, 32'd0);
    check_eq("t6_emit", {16'd0, emit_count}, 32'd0);
    step();
    check_eq("t6_still_empty", {31'd0, bus.inst_valid}, 32'd0);

    // Flush with a same-cycle pop still counts the handshake
    bus.req_valid = 1'b1;
    bus.req_code  = 4'd8;
    step();
    bus.req_valid  = 1'b0;
    flush          = 1'b1;
    bus.inst_ready = 1'b1;
    step();
    flush = 1'b0;
    check_eq("t7_emit", {16'd0, emit_count}, 32'd1);
    check_eq("t7_valid", {31'd0, bus.inst_valid}, 32'd0);

    // Sustained streaming and emit_count wrap
    do_reset();
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      bus.req_valid = 1'b1;
      bus.req_code  = {3'b000, i[0]};
      step();
      if (i == 100) begin
        check_eq("t8_stream_valid", {31'd0, bus.inst_valid}, 32'd1);
        check_eq("t8_stream_emit", {16'd0, emit_count}, 32'd100);
      end
    end
    bus.req_valid = 1'b0;
    check_eq("t8_emit_max", {16'd0, emit_count}, 32'h0000_FFFF);
    check_eq("t8_inst", bus.inst, 32'h0010_2013);
    check_eq("t8_open", {25'd0, open_phases}, 32'd0);
    step();
    check_eq("t8_wrap", {16'd0, emit_count}, 32'd0);
    check_eq("t8_empty", {31'd0, bus.inst_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/info_marker_gen.md
INFO_MARKER_GEN -- requirements
Module: info_marker_gen

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, queued marker capacity; power of two, 2..16.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  phase-event request present.
REQ-005 SHALL have port req_code  input  4  event code: 0/1 VCTM start/end, 2/3 DELAY, 4/5 TEXE, 6/7 LEAK, 8/9 INIT, 10/11 BIM, 12/13 TRAIN.
REQ-006 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 SHALL have port flush  input  1  synchronous clear of queue and phase state.
REQ-008 SHALL have port inst_valid  output  1  marker instruction word available.
REQ-009 SHALL have port inst  output  32  marker instruction word.
REQ-010 SHALL have port inst_ready  input  1  consumer takes inst this cycle when high with inst_valid.
REQ-011 SHALL have port open_phases  output  7  bit p set while phase p (code>>1) is open.
REQ-012 SHALL have port err_illegal  output  1  sticky: code 14 or 15 was presented.
REQ-013 SHALL have port err_order  output  1  sticky: ordering violation (only with INFO_PHASE_CHECK_EN).
REQ-014 SHALL have port emit_count  output  16  number of completed inst handshakes.

Function
REQ-015 SHALL encode inst = {8'h00, code[3:0], 20'h02013} (slti x0,x0,code); code 0 -> 32'h00002013, code 13 -> 32'h00d02013.
REQ-016 SHALL drive req_ready = !full && !flush.
REQ-017 SHALL consume codes 14/15 on handshake without queuing them, and set err_illegal.
REQ-018 SHALL push legal accepted codes into a FIFO of FIFO_DEPTH entries; inst/inst_valid driven from the head.
REQ-019 SHALL make inst_valid rise no earlier than the cycle after acceptance; minimum latency 1 cycle.
REQ-020 SHALL hold inst stable while inst_valid && !inst_ready.
REQ-021 SHALL support push and pop in the same cycle when not full; occupancy is unchanged.
REQ-022 SHALL sustain one marker per cycle when inst_ready is held high.
REQ-023 SHALL on an accepted start code set open_phases[code>>1]; on an accepted end code clear it; updates happen at acceptance, not emission.
REQ-024 SHALL increment emit_count on each inst handshake; wraps 16'hFFFF -> 0.
REQ-025 SHALL on flush empty the FIFO, drop inst_valid next cycle, and clear open_phases; err_* and emit_count SHALL be retained.
REQ-026 SHALL give flush priority over a same-cycle push; a same-cycle pop still counts in emit_count.

Reset
REQ-027 SHALL, on reset_n low, asynchronously clear FIFO pointers and occupancy, inst_valid=0, inst=0, open_phases=0, err_illegal=0, err_order=0, emit_count=0.
REQ-028 SHALL discard in-flight entries when reset asserts mid-operation; req_ready=1 the first cycle after release.

Configuration
REQ-029 SHALL compile ordering checks in only when INFO_PHASE_CHECK_EN is defined.
REQ-030 With INFO_PHASE_CHECK_EN, SHALL consume and drop (not queue) an end code for a closed phase or a start code for an already-open phase, and set err_order; open_phases unchanged.
REQ-031 Without INFO_PHASE_CHECK_EN, SHALL queue every legal code and tie err_order to 0.

Verification
REQ-032 Reset, push code 4, inst_ready=1 -> inst_valid next cycle, inst=32'h00402013, open_phases=7'b0000100, emit_count=1.
REQ-033 inst_ready=0, push 0,2,4,6 (FIFO_DEPTH=4) -> req_ready=0 after 4th; then inst_ready=1 -> 00002013, 00202013, 00402013, 00602013 in order, one per cycle.
REQ-034 Push code 15 -> accepted, nothing emitted, err_illegal=1 and stays 1.
REQ-035 With INFO_PHASE_CHECK_EN, push code 7 from reset -> dropped, err_order=1; without it -> 32'h00702013 emitted, err_order=0.
REQ-036 Queue 3 markers, assert flush with req_valid high -> push ignored, inst_valid=0 next cycle, open_phases=0, emit_count unchanged.
REQ-037 Preload emit_count to 16'hFFFF (65535 handshakes), one more handshake -> emit_count=0.
